// File: rtl/fpu_pkg.sv
// Shared floating-point package: binary32 constants, flag bit positions and
// the normalize-stage payload used by the multiplier post-processing stage.
package fpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned EXP_W       = 10;  // signed exponent path, covers -127..384
  localparam int unsigned EXP_FIELD_W = 8;
  localparam int unsigned MANT_W      = 23;
  localparam int unsigned PROD_W      = 48;
  localparam int unsigned FLAG_W      = 4;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam logic [XLEN-1:0] QNAN = 32'h7FC0_0000;

  // Bit positions inside {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  // Normalized product waiting for rounding; exp is two's complement
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              g;
    logic              s;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
  } s1_payload_t;

endpackage

// File: rtl/fp_mul_round_stage_if.sv
// Handshake bundle between the multiplier core, the round stage and its consumer.
//   in_*  : product from the multiplier core (valid/ready)
//   out_* : packed binary32 result and flags {invalid, overflow, underflow, inexact}
// slave  = round stage view, master = upstream/downstream environment view.
interface fp_mul_round_stage_if;
  import fpu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [PROD_W-1:0]   in_prod_mant;
  logic [EXP_W-1:0]    in_exp_sum;
  logic                in_sign;
  logic                in_is_nan;
  logic                in_is_inf;
  logic                in_is_zero;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [FLAG_W-1:0]   out_flags;

  modport slave (
    input  in_valid, in_prod_mant, in_exp_sum, in_sign, in_is_nan, in_is_inf, in_is_zero,
    input  out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_prod_mant, in_exp_sum, in_sign, in_is_nan, in_is_inf, in_is_zero,
    output out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a 23-bit fraction with guard/sticky.
//   mant, g, s, exp    : unrounded fraction, guard, sticky, signed exponent
//   rnd_mant, rnd_exp  : rounded fraction and exponent (bumped on carry-out)
//   inexact            : any discarded bit was set
module fp_round_rne
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              s,
  input  logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] rnd_mant,
  output logic [EXP_W-1:0]  rnd_exp,
  output logic              inexact
);

  logic              round_up;
  logic [MANT_W:0]   sum;

  // Ties go to the even neighbour: only round a tie up when the LSB is odd
  assign round_up = g & (s | mant[0]);
  assign sum      = {1'b0, mant} + (MANT_W+1)'(round_up);

  // Carry-out leaves the fraction all zeros and moves the hidden one up
  assign rnd_mant = sum[MANT_W-1:0];
  assign rnd_exp  = sum[MANT_W] ? exp + EXP_W'(1) : exp;
  assign inexact  = g | s;

endmodule

// File: rtl/fp_mul_round_stage.sv
// Two-stage post-processing for the binary32 multiplier: S1 normalizes the raw
// 48-bit product, S2 rounds (RNE), handles overflow/underflow/specials and
// holds the packed result.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fp_mul_round_stage_if (input and output handshakes)
module fp_mul_round_stage
  import fpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_mul_round_stage_if.slave  bus
);

  s1_payload_t        nrm_c;
  s1_payload_t        s1;
  logic               s1_valid;
  logic               s1_en;
  logic               s2_en;

  logic [MANT_W-1:0]  rnd_mant;
  logic [EXP_W-1:0]   rnd_exp;
  logic               rnd_inexact;
  logic signed [EXP_W-1:0] rexp_s;
  logic [XLEN-1:0]    res_c;
  logic [FLAG_W-1:0]  flags_c;

  // S2 moves when empty or drained; S1 moves when empty or emptied into S2
  assign s2_en        = !bus.out_valid || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  // Normalize: product of two [1,2) significands lies in [1,4)
  always_comb begin
    nrm_c         = '0;
    nrm_c.sign    = bus.in_sign;
    nrm_c.is_nan  = bus.in_is_nan;
    nrm_c.is_inf  = bus.in_is_inf;
    nrm_c.is_zero = bus.in_is_zero;
    if (bus.in_prod_mant[PROD_W-1]) begin
      nrm_c.mant = bus.in_prod_mant[46:24];
      nrm_c.g    = bus.in_prod_mant[23];
      nrm_c.s    = |bus.in_prod_mant[22:0];
      nrm_c.exp  = bus.in_exp_sum + EXP_W'(1);
    end else begin
      nrm_c.mant = bus.in_prod_mant[45:23];
      nrm_c.g    = bus.in_prod_mant[22];
      nrm_c.s    = |bus.in_prod_mant[21:0];
      nrm_c.exp  = bus.in_exp_sum;
    end
  end

  fp_round_rne u_round (
    .mant     (s1.mant),
    .g        (s1.g),
    .s        (s1.s),
    .exp      (s1.exp),
    .rnd_mant (rnd_mant),
    .rnd_exp  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  assign rexp_s = $signed(rnd_exp);

  // Result selection, specials first, then range checks on the rounded exponent
  always_comb begin
    res_c   = '0;
    flags_c = '0;
    if (s1.is_nan || (s1.is_inf && s1.is_zero)) begin
      res_c                 = QNAN;
      flags_c[FLAG_INVALID] = s1.is_inf & s1.is_zero;
    end else if (s1.is_inf) begin
      res_c = {s1.sign, {EXP_FIELD_W{1'b1}}, MANT_W'(0)};
    end else if (s1.is_zero) begin
      res_c = {s1.sign, (XLEN-1)'(0)};
    end else if (rexp_s >= $signed(EXP_W'(EXP_MAX))) begin
      res_c                  = {s1.sign, {EXP_FIELD_W{1'b1}}, MANT_W'(0)};
      flags_c[FLAG_OVERFLOW] = 1'b1;
      flags_c[FLAG_INEXACT]  = 1'b1;
    end else if (rexp_s <= $signed(EXP_W'(0))) begin
      res_c                   = {s1.sign, (XLEN-1)'(0)};
      flags_c[FLAG_UNDERFLOW] = 1'b1;
      flags_c[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_c                 = {s1.sign, rnd_exp[EXP_FIELD_W-1:0], rnd_mant};
      flags_c[FLAG_INEXACT] = rnd_inexact;
    end
  end

  // Pipeline registers; data only loads with a valid item so a stalled output holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1             <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1 <= nrm_c;
      end
      if (s2_en) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_result <= res_c;
          bus.out_flags  <= flags_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Self-checking bench for fp_mul_round_stage: directed vectors, backpressure,
// reset mid-flight and a randomized stream against an arithmetic reference model.
module tb_fp_mul_round_stage;
  import fpu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fp_mul_round_stage_if bus ();

  fp_mul_round_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [35:0] exp_q[$];
  logic [47:0] cur_prod;
  int          cur_exp;
  bit          cur_sign, cur_nan, cur_inf, cur_zero;
  bit          prev_stall;
  logic [35:0] held;
  int          n_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: scale the product by a power of two, round with integer remainders
  function automatic logic [35:0] ref_model(input logic [47:0] prod, input int es,
                                            input bit sg, input bit nan, input bit inf,
                                            input bit zero);
    longint unsigned p, q, rem, half;
    int  sh, e;
    bit  inx;
    if (nan || (inf && zero)) return {(inf && zero) ? 4'b1000 : 4'b0000, 32'h7FC0_0000};
    if (inf)  return {4'b0000, sg, 8'hFF, 23'h0};
    if (zero) return {4'b0000, sg, 31'h0};
    p    = 64'(prod);
    sh   = prod[47] ? 24 : 23;
    e    = es + (prod[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= int'(EXP_MAX)) return {4'b0101, sg, 8'hFF, 23'h0};
    if (e <= 0)             return {4'b0011, sg, 31'h0};
    return {3'b000, inx, sg, 8'(e), q[22:0]};
  endfunction

  task automatic gen_item();
    logic [22:0] ma, mb;
    int unsigned sel;
    ma  = 23'($urandom);
    mb  = 23'($urandom);
    sel = $urandom_range(0, 7);
    if (sel == 0) ma = '1;
    if (sel == 1) begin ma = '1; mb = 23'd1; end
    cur_prod = 48'({1'b1, ma}) * 48'({1'b1, mb});
    sel = $urandom_range(0, 9);
    case (sel)
      0:       cur_exp = int'($urandom_range(0, 6)) - 3;
      1:       cur_exp = 250 + int'($urandom_range(0, 8));
      2:       cur_exp = int'($urandom_range(0, 511)) - int'(BIAS);
      default: cur_exp = 1 + int'($urandom_range(0, 253));
    endcase
    cur_sign = 1'($urandom);
    cur_nan  = ($urandom_range(0, 15) == 0);
    cur_inf  = ($urandom_range(0, 11) == 0);
    cur_zero = ($urandom_range(0, 11) == 0);
  endtask

  // One cycle of driving; observes both handshakes just before the next rising edge
  task automatic step(input bit v, input bit r, output bit acc);
    logic [35:0] e;
    @(negedge clk);
    bus.in_valid     = v;
    bus.out_ready    = r;
    bus.in_prod_mant = cur_prod;
    bus.in_exp_sum   = 10'(cur_exp);
    bus.in_sign      = cur_sign;
    bus.in_is_nan    = cur_nan;
    bus.in_is_inf    = cur_inf;
    bus.in_is_zero   = cur_zero;
    #1;
    if (prev_stall) check("hold", 64'({bus.out_flags, bus.out_result}), 64'(held));
    prev_stall = bus.out_valid && !bus.out_ready;
    held       = {bus.out_flags, bus.out_result};
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("stream", 64'({bus.out_flags, bus.out_result}), 64'(e));
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      exp_q.push_back(ref_model(cur_prod, cur_exp, cur_sign, cur_nan, cur_inf, cur_zero));
      gen_item();
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 1'b1, acc);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Single item with exact latency: absent after one edge, present after two
  task automatic dir_check(input string tag, input logic [47:0] prod, input int es,
                           input bit sg, input bit nan, input bit inf, input bit zero,
                           input logic [35:0] expv);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    bus.in_prod_mant = prod;
    bus.in_exp_sum   = 10'(es);
    bus.in_sign      = sg;
    bus.in_is_nan    = nan;
    bus.in_is_inf    = inf;
    bus.in_is_zero   = zero;
    #1;
    check({tag, "_accept"}, 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check(tag, 64'({bus.out_flags, bus.out_result}), 64'(expv));
  endtask

  initial begin
    bit acc;
    int accepted;
    n_checks   = 0;
    n_errors   = 0;
    n_out      = 0;
    prev_stall = 1'b0;
    held       = '0;
    rst        = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_prod_mant = '0; bus.in_exp_sum = '0;
    bus.in_sign = 1'b0; bus.in_is_nan = 1'b0; bus.in_is_inf = 1'b0; bus.in_is_zero = 1'b0;
    gen_item();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.out_result), 64'(0));
    check("rst_flags", 64'(bus.out_flags), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    dir_check("mul_1p5", 48'h9000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0000, 32'h4010_0000});
    dir_check("rne_tie_carry", {2'b01, 23'h7FFFFF, 1'b1, 22'h0}, 127, 1'b0, 1'b0, 1'b0, 1'b0,
              {4'b0001, 32'h4000_0000});
    dir_check("rne_tie_even", {2'b01, 23'h7FFFFE, 1'b1, 22'h0}, 127, 1'b0, 1'b0, 1'b0, 1'b0,
              {4'b0001, 32'h3FFF_FFFE});
    dir_check("overflow", 48'h8000_0000_0000, 254, 1'b1, 1'b0, 1'b0, 1'b0, {4'b0101, 32'hFF80_0000});
    dir_check("underflow", 48'h4000_0000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, {4'b0011, 32'h8000_0000});
    dir_check("inf_x_zero", 48'h4000_0000_0000, 127, 1'b0, 1'b0, 1'b1, 1'b1, {4'b1000, 32'h7FC0_0000});
    dir_check("inf_neg", 48'h4000_0000_0000, 127, 1'b1, 1'b0, 1'b1, 1'b0, {4'b0000, 32'hFF80_0000});
    dir_check("nan", 48'h4000_0000_0000, 127, 1'b0, 1'b1, 1'b0, 1'b0, {4'b0000, 32'h7FC0_0000});
    dir_check("zero_neg", 48'h4000_0000_0000, 127, 1'b1, 1'b0, 1'b0, 1'b1, {4'b0000, 32'h8000_0000});
    step(1'b0, 1'b1, acc);

    // Backpressure: two items fill the pipe, then in_ready must drop
    n_out    = 0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, acc);
      if (acc) accepted++;
      if (i == 2) check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
    end
    check("bp_accepted", 64'(accepted), 64'(2));
    for (int i = 0; i < 20 && accepted < 5; i++) begin
      step(1'b1, 1'b1, acc);
      if (acc) accepted++;
    end
    drain();
    check("bp_outputs", 64'(n_out), 64'(5));

    // Reset with items in flight: nothing may come out afterwards
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, acc);
      check("rst_no_stale", 64'(bus.out_valid), 64'(0));
    end

    // Randomized stream with random backpressure
    for (int i = 0; i < 3000; i++) step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
